// File: rtl/softmax_div_pkg.sv
// ---------------------------------------------------------------------------
// softmax_div_pkg
// Shared definitions for the softmax divide issuer: default widths and
// depths, the result record carried through the result FIFO, and a helper
// that sizes occupancy counters (one extra bit so "full" is representable).
// ---------------------------------------------------------------------------
package softmax_div_pkg;

    localparam int DEF_A_WIDTH    = 32;
    localparam int DEF_B_WIDTH    = 32;
    localparam int DEF_LATENCY    = 63;
    localparam int DEF_FIFO_DEPTH = 64;

    // Counter width able to hold 0..FIFO_DEPTH inclusive.
    localparam int CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;

    // One collected divider result, in FIFO order.
    typedef struct packed {
        logic [DEF_A_WIDTH-1:0] quotient;
        logic [DEF_B_WIDTH-1:0] remainder;
        logic                   div0;
        logic                   last;
    } result_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/softmax_res_fifo.sv
// ---------------------------------------------------------------------------
// softmax_res_fifo
// Synchronous result FIFO. Head entry is presented on data_o one cycle after
// it is pushed; data_o reads as zero while empty. Pointers carry an extra
// wrap bit so full and empty are distinguished without a separate flag.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   push_i     write data_i this cycle
//   data_i     entry to write
//   pop_i      consumer ready; pops the head when valid_o is high
//   data_o     head entry (zero when empty)
//   valid_o    FIFO non-empty
//   count_o    current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module softmax_res_fifo
    import softmax_div_pkg::*;
#(
    parameter type T     = result_t,
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter int  CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T            mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_pop;
    logic        full;

    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full    = (count_o == CW'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Upstream credit accounting must never let a push land on a full FIFO
    // unless the head leaves in the same cycle.
    assert property (@(posedge clk) disable iff (rst) !(push_i && full && !do_pop));

endmodule

// File: rtl/softmax_div_issuer.sv
// ---------------------------------------------------------------------------
// softmax_div_issuer
// Feeds a fixed-latency pipelined unsigned divider with one dividend per cycle
// against a shared divisor, and collects quotients in issue order into a
// result FIFO. The divider is never stalled: a credit check (in-flight plus
// buffered results below FIFO depth) guarantees every returning result has a
// FIFO slot.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cfg_load, cfg_divisor       latch a new divisor (only while not busy)
//   s_valid/s_ready/s_dividend/s_last   dividend stream in
//   div_en/div_a/div_b          divider inputs
//   div_quotient/div_remainder/div_by_0 divider outputs
//   m_valid/m_ready/m_quotient/m_remainder/m_div0/m_last  result stream out
//   busy                        work in flight or results buffered
// ---------------------------------------------------------------------------
module softmax_div_issuer
    import softmax_div_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int B_WIDTH    = DEF_B_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [B_WIDTH-1:0] cfg_divisor,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [A_WIDTH-1:0] s_dividend,
    input  logic               s_last,
    output logic               div_en,
    output logic [A_WIDTH-1:0] div_a,
    output logic [B_WIDTH-1:0] div_b,
    input  logic [A_WIDTH-1:0] div_quotient,
    input  logic [B_WIDTH-1:0] div_remainder,
    input  logic               div_by_0,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [A_WIDTH-1:0] m_quotient,
    output logic [B_WIDTH-1:0] m_remainder,
    output logic               m_div0,
    output logic               m_last,
    output logic               busy
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    typedef struct packed {
        logic [A_WIDTH-1:0] quotient;
        logic [B_WIDTH-1:0] remainder;
        logic               div0;
        logic               last;
    } res_t;

    logic               en_q;
    logic [B_WIDTH-1:0] divisor_q;
    logic [LATENCY-1:0] tag_valid_q;
    logic [LATENCY-1:0] tag_last_q;
    logic [CW-1:0]      inflight_q;
    logic [CW-1:0]      inflight_d;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credits_used;
    logic               fire;
    logic               tag_exit;
    res_t               push_data;
    res_t               head;

    // Every accepted dividend consumes a credit until its result is popped,
    // so the FIFO can always absorb whatever the divider returns.
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign s_ready      = !rst && !cfg_load && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign fire         = s_valid && s_ready;
    assign tag_exit     = tag_valid_q[LATENCY-1];

    assign div_en = en_q;
    assign div_a  = fire ? s_dividend : '0;
    assign div_b  = divisor_q;

    assign busy = (inflight_q != '0) || m_valid;

    always_comb begin
        inflight_d = inflight_q;
        if (fire && !tag_exit) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!fire && tag_exit) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // The tag line runs in lockstep with the divider pipeline; clearing it on
    // reset is what keeps stale divider contents out of the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            divisor_q   <= '0;
            tag_valid_q <= '0;
            tag_last_q  <= '0;
            inflight_q  <= '0;
        end else begin
            en_q <= 1'b1;
            if (cfg_load && !busy) begin
                divisor_q <= cfg_divisor;
            end
            tag_valid_q[0] <= fire;
            tag_last_q[0]  <= s_last;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    assign push_data.quotient  = div_quotient;
    assign push_data.remainder = div_remainder;
    assign push_data.div0      = div_by_0;
    assign push_data.last      = tag_last_q[LATENCY-1];

    softmax_res_fifo #(
        .T     (res_t),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_exit),
        .data_i  (push_data),
        .pop_i   (m_ready),
        .data_o  (head),
        .valid_o (m_valid),
        .count_o (fifo_count)
    );

    assign m_quotient  = head.quotient;
    assign m_remainder = head.remainder;
    assign m_div0      = head.div0;
    assign m_last      = head.last;

endmodule

// File: tb/tb_softmax_div_issuer.sv
// ---------------------------------------------------------------------------
// tb_softmax_div_issuer
// Drives dividend streams into softmax_div_issuer, models the divider as a
// LATENCY-deep delay line, and checks every collected result against a
// scoreboard of expectations built from the intended divisor.
// ---------------------------------------------------------------------------
module tb_softmax_div_issuer;

    localparam int LAT   = 63;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [31:0] cfg_divisor;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_dividend;
    logic        s_last;
    logic        div_en;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_by_0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_quotient;
    logic [31:0] m_remainder;
    logic        m_div0;
    logic        m_last;
    logic        busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic        last;
        int          fireCycle;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        expEntry;
    logic [31:0] expDivisor = '0;
    int          assertCount = 0;
    int          failCount = 0;
    int          cycleCnt = 0;
    int          popCount = 0;
    bit          checkLatency = 1'b0;
    bit          randomReady = 1'b0;

    logic [31:0] pipeQ [LAT];
    logic [31:0] pipeR [LAT];
    logic        pipeZ [LAT];

    softmax_div_issuer #(
        .A_WIDTH    (32),
        .B_WIDTH    (32),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load      (cfg_load),
        .cfg_divisor   (cfg_divisor),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_dividend    (s_dividend),
        .s_last        (s_last),
        .div_en        (div_en),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_by_0      (div_by_0),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_quotient    (m_quotient),
        .m_remainder   (m_remainder),
        .m_div0        (m_div0),
        .m_last        (m_last),
        .busy          (busy)
    );

    // Free-running clock plus a cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Divider model: results appear LAT cycles after div_a/div_b are sampled,
    // divide-by-zero saturates the quotient and returns the dividend.
    always @(posedge clk) begin
        if (div_en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipeQ[i] <= pipeQ[i-1];
                pipeR[i] <= pipeR[i-1];
                pipeZ[i] <= pipeZ[i-1];
            end
            pipeQ[0] <= (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
            pipeR[0] <= (div_b == 0) ? div_a : div_a % div_b;
            pipeZ[0] <= (div_b == 0);
        end
    end

    assign div_quotient  = pipeQ[LAT-1];
    assign div_remainder = pipeR[LAT-1];
    assign div_by_0      = pipeZ[LAT-1];

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Scoreboard: record an expectation on every accepted dividend and
    // compare on every consumed result. Reset discards all expectations.
    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
        end else begin
            if (s_valid && s_ready) begin
                expEntry.q         = (expDivisor == 0) ? 32'hFFFF_FFFF : s_dividend / expDivisor;
                expEntry.r         = (expDivisor == 0) ? s_dividend : s_dividend % expDivisor;
                expEntry.z         = (expDivisor == 0);
                expEntry.last      = s_last;
                expEntry.fireCycle = cycleCnt;
                sbQ.push_back(expEntry);
            end
            if (m_valid && m_ready) begin
                popCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected result", 64'(m_quotient), 64'd0 - 1);
                end else begin
                    expEntry = sbQ.pop_front();
                    checkOutput("quotient", 64'(m_quotient), 64'(expEntry.q));
                    checkOutput("remainder", 64'(m_remainder), 64'(expEntry.r));
                    checkOutput("div0", 64'(m_div0), 64'(expEntry.z));
                    checkOutput("last", 64'(m_last), 64'(expEntry.last));
                    if (checkLatency) begin
                        checkOutput("latency", 64'(cycleCnt - expEntry.fireCycle), 64'(LAT + 1));
                    end
                end
            end
        end
    end

    // Offer one dividend and hold it until accepted (bounded wait).
    // Called and returns just after a rising edge.
    task automatic applyStimulus(input logic [31:0] dividend, input logic last);
        bit accepted = 1'b0;
        s_valid    = 1'b1;
        s_dividend = dividend;
        s_last     = last;
        for (int n = 0; n < 1000 && !accepted; n++) begin
            @(negedge clk);
            accepted = s_ready;
            @(posedge clk);
            #1;
            if (randomReady) m_ready = 1'($urandom_range(0, 1));
        end
        if (!accepted) begin
            checkOutput("accept timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadDivisor(input logic [31:0] d, input bit takes);
        cfg_load    = 1'b1;
        cfg_divisor = d;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        if (takes) expDivisor = d;
    endtask

    // Wait for the block to drain completely, then confirm nothing is owed.
    task automatic waitIdle();
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            done = !busy;
            @(posedge clk);
            #1;
        end
        checkOutput("idle reached", 64'(done), 64'd1);
        checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int accCnt;
        int staleCnt;
        int popStart;

        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_divisor = '0;
        s_valid     = 1'b0;
        s_dividend  = '0;
        s_last      = 1'b0;
        m_ready     = 1'b1;
        idleCycles(3);

        // Reset state
        @(negedge clk);
        checkOutput("reset s_ready", 64'(s_ready), 64'd0);
        checkOutput("reset m_valid", 64'(m_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset div_en", 64'(div_en), 64'd0);
        checkOutput("reset m_quotient", 64'(m_quotient), 64'd0);
        checkOutput("reset m_last", 64'(m_last), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(1);
        @(negedge clk);
        checkOutput("div_en after reset", 64'(div_en), 64'd1);
        checkOutput("s_ready after reset", 64'(s_ready), 64'd1);
        checkOutput("div_b after reset", 64'(div_b), 64'd0);
        @(posedge clk);
        #1;

        // Test 1: divisor 4, dividends 8..15 back-to-back, exact latency
        $display("[TB] test 1: basic stream");
        loadDivisor(32'd4, 1'b1);
        checkLatency = 1'b1;
        for (int i = 8; i < 16; i++) applyStimulus(32'(i), i == 15);
        s_valid = 1'b0;
        waitIdle();
        checkLatency = 1'b0;

        // Test 2: output blocked, credits cap acceptance at FIFO depth
        $display("[TB] test 2: backpressure");
        loadDivisor(32'd5, 1'b1);
        m_ready = 1'b0;
        accCnt  = 0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            s_dividend = 32'(1000 + accCnt * 7);
            @(negedge clk);
            if (s_ready) accCnt++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        checkOutput("accepted while blocked", 64'(accCnt), 64'(DEPTH));
        @(negedge clk);
        checkOutput("s_ready when full", 64'(s_ready), 64'd0);
        checkOutput("busy when full", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitIdle();
        for (int i = 0; i < 4; i++) applyStimulus(32'(33 + i), i == 3);
        s_valid = 1'b0;
        waitIdle();

        // Test 3: divide by zero, then zero dividend
        $display("[TB] test 3: zero cases");
        loadDivisor(32'd0, 1'b1);
        applyStimulus(32'd100, 1'b1);
        s_valid = 1'b0;
        waitIdle();
        loadDivisor(32'd7, 1'b1);
        applyStimulus(32'd0, 1'b1);
        s_valid = 1'b0;
        waitIdle();

        // Test 4: divisor load while busy is ignored
        $display("[TB] test 4: cfg_load while busy");
        loadDivisor(32'd3, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(32'(20 + i * 5), 1'b0);
        s_dividend  = 32'd77;
        cfg_load    = 1'b1;
        cfg_divisor = 32'd9;
        @(negedge clk);
        checkOutput("s_ready in cfg cycle", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(32'(77 + i * 4), i == 4);
        s_valid = 1'b0;
        waitIdle();
        loadDivisor(32'd9, 1'b1);
        applyStimulus(32'd81, 1'b1);
        s_valid = 1'b0;
        waitIdle();

        // Test 5: reset with work in flight and buffered
        $display("[TB] test 5: reset mid-operation");
        loadDivisor(32'd2, 1'b1);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(32'(500 + i), 1'b0);
        s_valid = 1'b0;
        idleCycles(60);
        for (int i = 0; i < 40; i++) applyStimulus(32'(600 + i), 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        checkOutput("results buffered before reset", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("m_valid after mid reset", 64'(m_valid), 64'd0);
        checkOutput("busy after mid reset", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        expDivisor = '0;
        m_ready    = 1'b1;
        staleCnt   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) staleCnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("stale results", 64'(staleCnt), 64'd0);

        // Test 6: random consumer, s_last every 10th element
        $display("[TB] test 6: random backpressure");
        loadDivisor(32'd6, 1'b1);
        popStart    = popCount;
        randomReady = 1'b1;
        for (int i = 0; i < 100; i++) applyStimulus($urandom, (i % 10) == 9);
        s_valid     = 1'b0;
        randomReady = 1'b0;
        m_ready     = 1'b1;
        waitIdle();
        checkOutput("results consumed", 64'(popCount - popStart), 64'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
